// File: rtl/comparator_pkg.sv
// Shared types and configuration check for the chunked comparator pipeline.
package comparator_pkg;

  // Widest operand a pipeline instance may carry through its stages
  localparam int unsigned MAX_W = 64;

  // Per-stage payload: control flags plus the operand bits still to be resolved,
  // left-aligned so the next chunk to examine always sits at the top.
  typedef struct packed {
    logic             valid;
    logic             decided;
    logic             lt;
    logic             gt;
    logic             eq;
    logic             is_signed;
    logic [MAX_W-1:0] a_rem;
    logic [MAX_W-1:0] b_rem;
  } stage_t;

  // Legal when the operand splits evenly into non-empty chunks and fits the payload
  function automatic bit cfg_ok(input int unsigned n, input int unsigned chunk);
    return (chunk != 0) && (chunk <= n) && ((n % chunk) == 0) && (n <= MAX_W);
  endfunction

endpackage

// File: rtl/comparator_pipe_cmp_stage.sv
// One pipeline stage: resolves the top CHUNK bits of the remaining operands.
module cmp_stage
  import comparator_pkg::*;
#(
  parameter int unsigned CHUNK = 8
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   en,
  input  stage_t d,
  output stage_t q
);

  logic [CHUNK-1:0] chunk_a;
  logic [CHUNK-1:0] chunk_b;
  stage_t           nxt;

  // Decide on the first unequal chunk; an earlier decision passes through untouched
  always_comb begin
    nxt     = '0;
    chunk_a = d.a_rem[MAX_W-1 -: CHUNK];
    chunk_b = d.b_rem[MAX_W-1 -: CHUNK];
    if (d.valid) begin
      nxt       = d;
      nxt.a_rem = d.a_rem << CHUNK;
      nxt.b_rem = d.b_rem << CHUNK;
      if (!d.decided && (chunk_a != chunk_b)) begin
        nxt.decided = 1'b1;
        nxt.lt      = (chunk_a < chunk_b);
        nxt.gt      = (chunk_a > chunk_b);
      end
      nxt.eq = !nxt.decided;
    end
  end

  // Stage register; holds during a global stall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      q <= nxt;
    end
  end

endmodule

// File: rtl/comparator_pipe.sv
// Pipelined magnitude comparator resolving CHUNK bits per stage, MSB chunk first.
module comparator_pipe
  import comparator_pkg::*;
#(
  parameter int unsigned N     = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         is_signed,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         lt,
  output logic         eq,
  output logic         gt
);

  localparam int unsigned S = ((CHUNK == 0) || (CHUNK > N)) ? 1 : (N / CHUNK);

  if (!cfg_ok(N, CHUNK)) begin : g_bad_cfg
    $error("comparator_pipe: N must be a non-zero multiple of CHUNK and at most MAX_W");
  end

  logic         advance;
  logic [N-1:0] sign_flip;
  stage_t       stage_in;
  stage_t       stage_q [S];
  logic         unused_tail;

  // Whole pipeline moves together unless the held output is refused
  assign advance  = out_ready || !out_valid;
  assign in_ready = advance;

  // Flipping the sign bit maps two's-complement order onto unsigned order
  assign sign_flip = N'(is_signed) << (N - 1);

  // Capture operands left-aligned into the payload
  always_comb begin
    stage_in           = '0;
    stage_in.valid     = in_valid;
    stage_in.is_signed = is_signed;
    stage_in.a_rem     = MAX_W'(a ^ sign_flip) << (MAX_W - N);
    stage_in.b_rem     = MAX_W'(b ^ sign_flip) << (MAX_W - N);
  end

  for (genvar k = 0; k < S; k++) begin : g_stage
    if (k == 0) begin : g_first
      cmp_stage #(.CHUNK(CHUNK)) u_stage (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (advance),
        .d     (stage_in),
        .q     (stage_q[k])
      );
    end else begin : g_next
      cmp_stage #(.CHUNK(CHUNK)) u_stage (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (advance),
        .d     (stage_q[k-1]),
        .q     (stage_q[k])
      );
    end
  end

  // Final stage flops drive the result directly
  assign out_valid = stage_q[S-1].valid;
  assign lt        = stage_q[S-1].lt;
  assign eq        = stage_q[S-1].eq;
  assign gt        = stage_q[S-1].gt;

  // Leftover payload of the last stage has no consumer
  assign unused_tail = ^{stage_q[S-1].a_rem, stage_q[S-1].b_rem,
                         stage_q[S-1].is_signed, stage_q[S-1].decided};

endmodule

// File: tb/tb_comparator_pipe.sv
// Self-checking bench for comparator_pipe (N=16, CHUNK=4) with a scoreboard model.
module tb_comparator_pipe;

  localparam int unsigned N     = 16;
  localparam int unsigned CHUNK = 4;
  localparam int          S     = N / CHUNK;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         is_signed;
  logic         out_valid;
  logic         out_ready;
  logic         lt;
  logic         eq;
  logic         gt;

  comparator_pipe #(.N(N), .CHUNK(CHUNK)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .is_signed (is_signed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .lt        (lt),
    .eq        (eq),
    .gt        (gt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] flags;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  bit   chk_lat = 0;
  bit   prev_stall = 0;
  bit   last_acc = 0;

  task automatic check(input string tag, input int got, input int want);
    n_tests++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  // Reference: full-width integer compare, {lt,eq,gt}
  function automatic logic [2:0] model(input logic [N-1:0] x, input logic [N-1:0] y,
                                       input logic sg);
    int sx;
    int sy;
    if (sg) begin
      sx = int'($signed(x));
      sy = int'($signed(y));
    end else begin
      sx = int'({16'h0, x});
      sy = int'({16'h0, y});
    end
    if (sx < sy) return 3'b100;
    if (sx == sy) return 3'b010;
    return 3'b001;
  endfunction

  // Compare outputs against the scoreboard and log any input acceptance
  task automatic observe();
    exp_t e;
    if (prev_stall) check("stall_hold_valid", int'(out_valid), 1);
    if (!out_valid) begin
      check("idle_flags_zero", int'({lt, eq, gt}), 0);
    end else begin
      check("onehot", $countones({lt, eq, gt}), 1);
      if (exp_q.size() == 0) begin
        check("unexpected_result", 1, 0);
      end else begin
        check("result", int'({lt, eq, gt}), int'(exp_q[0].flags));
        if (out_ready) begin
          e = exp_q.pop_front();
          if (chk_lat) check("latency", cyc - e.cyc, S);
        end
      end
    end
    prev_stall = out_valid && !out_ready;
    last_acc   = in_valid && in_ready;
    if (last_acc) exp_q.push_back('{flags: model(a, b, is_signed), cyc: cyc});
  endtask

  // One cycle: drive at negedge, observe settled values before the next posedge
  task automatic step(input logic iv, input logic [N-1:0] ia, input logic [N-1:0] ib,
                      input logic isg, input logic ordy);
    @(negedge clk);
    in_valid  = iv;
    a         = ia;
    b         = ib;
    is_signed = isg;
    out_ready = ordy;
    #1;
    cyc++;
    observe();
  endtask

  task automatic idle(input int n, input logic ordy);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, ordy);
  endtask

  task automatic drain_check(input string tag);
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) idle(1, 1'b1);
    check(tag, exp_q.size(), 0);
  endtask

  logic [N-1:0] ta [6];
  logic [N-1:0] tb [6];
  logic         ts [6];
  int           idx;

  initial begin
    clk = 1'b0; rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0;
    is_signed = 1'b0; out_ready = 1'b1;
    #12;
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_flags", int'({lt, eq, gt}), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single unsigned compare with fixed latency
    chk_lat = 1;
    step(1'b1, 16'h1234, 16'h1235, 1'b0, 1'b1);
    idle(S + 1, 1'b1);
    check("lt_1234_1235_done", exp_q.size(), 0);

    // Same operands, signed then unsigned, back to back
    step(1'b1, 16'h8000, 16'h0001, 1'b1, 1'b1);
    step(1'b1, 16'h8000, 16'h0001, 1'b0, 1'b1);
    step(1'b1, 16'hFFFF, 16'hFFFF, 1'b0, 1'b1);
    step(1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 1'b1);
    step(1'b1, 16'hF000, 16'h0FFF, 1'b0, 1'b1);
    idle(S + 1, 1'b1);
    check("directed_done", exp_q.size(), 0);
    chk_lat = 0;

    // Output blocked while six transactions are offered
    for (int i = 0; i < 6; i++) begin
      ta[i] = N'($urandom); tb[i] = N'($urandom); ts[i] = 1'($urandom);
    end
    idx = 0;
    for (int i = 0; i < 10; i++) begin
      if (idx < 6) step(1'b1, ta[idx], tb[idx], ts[idx], 1'b0);
      else idle(1, 1'b0);
      if (last_acc) idx++;
    end
    check("stall_accept_le_s1", int'(idx <= S + 1), 1);
    check("stall_in_ready_low", int'(in_ready), 0);
    for (int i = 0; i < 40 && idx < 6; i++) begin
      step(1'b1, ta[idx], tb[idx], ts[idx], 1'b1);
      if (last_acc) idx++;
    end
    check("stall_all_accepted", idx, 6);
    drain_check("stall_drained");

    // Reset with transactions in flight
    for (int i = 0; i < 3; i++) step(1'b1, N'($urandom), N'($urandom), 1'($urandom), 1'b0);
    idle(2, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_flags", int'({lt, eq, gt}), 0);
    exp_q.delete();
    prev_stall = 0;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold_valid", int'(out_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1, 1'b0);
    check("ready_after_rst", int'(in_ready), 1);
    idle(S + 2, 1'b1);

    // Random traffic with random back-pressure
    for (int i = 0; i < 10000; i++) begin
      logic [N-1:0] ra;
      logic [N-1:0] rb;
      int           sel;
      ra  = N'($urandom);
      sel = int'($urandom_range(0, 7));
      if (sel < 2)      rb = ra;
      else if (sel < 4) rb = {ra[N-1:N/2], N'($urandom) & N'(16'h00FF)} ;
      else              rb = N'($urandom);
      step(1'($urandom_range(0, 9) < 7), ra, rb, 1'($urandom),
           1'($urandom_range(0, 9) < 7));
    end
    drain_check("random_drained");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/comparator_pipe.md
COMPARATOR_PIPE -- requirements
Module: comparator_pipe

Interface
REQ-001 Parameter N, default 32: operand width in bits.
REQ-002 Parameter CHUNK, default 8: bits resolved per pipeline stage; S = N/CHUNK stages.
REQ-003 Port clk  input  1  rising-edge clock for all state.
REQ-004 Port rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port in_valid  input  1  operand pair and mode are valid this cycle.
REQ-006 Port in_ready  output  1  block accepts the input this cycle.
REQ-007 Port a  input  N  first operand.
REQ-008 Port b  input  N  second operand.
REQ-009 Port is_signed  input  1  1 = two's-complement compare, 0 = unsigned; sampled per transaction.
REQ-010 Port out_valid  output  1  result is valid.
REQ-011 Port out_ready  input  1  downstream accepts the result.
REQ-012 Port lt  output  1  a < b.
REQ-013 Port eq  output  1  a == b.
REQ-014 Port gt  output  1  a > b.

Function
REQ-015 A transfer SHALL occur on a rising edge where valid and ready are both 1, on each side independently.
REQ-016 Signed mode SHALL invert bit N-1 of both operands at capture, then compare unsigned.
REQ-017 Stage k (0..S-1) SHALL resolve chunk k counted from the MSB, and carry a decided flag plus lt/gt from earlier stages; a decided result passes through unchanged.
REQ-018 An undecided, unequal chunk SHALL set decided and set lt or gt by unsigned chunk magnitude.
REQ-019 A transaction undecided after stage S-1 SHALL report eq.
REQ-020 With out_ready held at 1, latency SHALL be exactly S cycles from the input transfer edge to out_valid.
REQ-021 Throughput SHALL be one transaction per cycle while no stall occurs.
REQ-022 The pipeline SHALL stall globally when out_valid=1 and out_ready=0; every stage holds its contents.
REQ-023 in_ready SHALL equal (out_ready OR NOT out_valid), combinationally.
REQ-024 Bubbles SHALL propagate as invalid stages and are not compacted during a stall.
REQ-025 When out_valid=1, exactly one of lt/eq/gt SHALL be 1.
REQ-026 When out_valid=0, lt, eq and gt SHALL all be 0.
REQ-027 Results SHALL leave in input order, none lost and none duplicated.
REQ-028 When S=1, the block SHALL behave as a single registered stage with latency 1.
REQ-029 N not divisible by CHUNK, or CHUNK > N, SHALL be an elaboration error.

Reset
REQ-030 While rst_n=0, all stage valid flags, out_valid, lt, eq and gt SHALL be 0, regardless of clk.
REQ-031 Reset mid-operation SHALL discard all in-flight transactions; none appear after release.
REQ-032 in_ready SHALL be 1 in the first cycle after reset release.

Structure
REQ-033 Package comparator_pkg SHALL hold the per-stage struct (valid, decided, lt, gt, remaining operand bits, signed flag) and the elaboration-check function.
REQ-034 One sub-module, cmp_stage, SHALL implement a single chunk stage; comparator_pipe instantiates S copies in a generate loop.

Verification (N=16, CHUNK=4, S=4)
REQ-035 Unsigned a=0x1234, b=0x1235, out_ready=1 -> out_valid 4 cycles later with lt=1, eq=0, gt=0.
REQ-036 a=0x8000, b=0x0001: is_signed=1 -> lt=1; is_signed=0 -> gt=1; issued back-to-back, results on consecutive cycles in order.
REQ-037 a=b=0xFFFF in both modes -> eq=1 each; a=0xF000, b=0x0FFF unsigned -> gt=1, decided at stage 0.
REQ-038 out_ready=0 while 6 transactions are offered -> in_ready drops once the output is occupied, at most S+1 accepted, all outputs held stable; out_ready=1 -> remaining results drain in order, none lost.
REQ-039 rst_n asserted with 3 transactions in flight -> outputs 0 immediately, no stale results after release, in_ready=1 in the first cycle after release.
REQ-040 Random 10k transactions with random in_valid/out_ready -> every result matches a reference model, exactly one flag set whenever out_valid=1.
